// File: rtl/sevseg_pkg.sv
// Shared constants and scan FSM state type for the seven-segment scanner.
package sevseg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;

  typedef enum logic {
    StBlank = 1'b0,
    StShow  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sevseg_lz_mask.sv
// Combinational leading-zero mask: bit i is cleared when digit i and every digit above it are zero.
module sevseg_lz_mask
  import sevseg_pkg::*;
(
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_fr_val,
  input  logic                          i_lz_blank,
  output logic [NUM_DIGITS-1:0]         o_mask
);

  // Digit 0 is never suppressed, so an all-zero value still shows one "0".
  always_comb begin
    o_mask = '1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (i_lz_blank && ((i_fr_val >> (DIGIT_W * i)) == '0)) begin
        o_mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sevseg_scan.sv
// Eight-digit common-anode scanner with per-slot blanking, tear-free frame latching and
// optional leading-zero suppression. Feeds sevseg_decode via o_nibble.
module sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]         i_value_dp,
  input  logic                          i_value_valid,
  input  logic [NUM_DIGITS-1:0]         i_digit_en,
  input  logic                          i_lz_blank,
  output logic [NUM_DIGITS-1:0]         o_an,
  output logic [DIGIT_W-1:0]            o_nibble,
  output logic                          o_dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
  output logic                          o_frame_start
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned ValW = NUM_DIGITS * DIGIT_W;
  localparam logic [CntW-1:0] CntLast   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  scan_state_t           r_state, w_state_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [IdxW-1:0]       r_idx, w_idx_d;
  logic [ValW-1:0]       r_sh_val, w_sh_val_d, r_fr_val, w_fr_val_d;
  logic [NUM_DIGITS-1:0] r_sh_dp, w_sh_dp_d, r_fr_dp, w_fr_dp_d;
  logic [NUM_DIGITS-1:0] r_an, w_an_d;
  logic [DIGIT_W-1:0]    r_nibble, w_nibble_d;
  logic                  r_dp_n, w_dp_n_d;
  logic                  r_frame_start, w_frame_start_d;
  logic                  w_tc, w_wrap;
  logic [NUM_DIGITS-1:0] w_lz_mask, w_visible;

  sevseg_lz_mask u_lz_mask (
    .i_fr_val  (r_fr_val),
    .i_lz_blank(i_lz_blank),
    .o_mask    (w_lz_mask)
  );

  assign w_visible = i_digit_en & w_lz_mask;

  always_comb begin
    w_tc       = (r_cnt == CntLast);
    w_wrap     = w_tc && (r_idx == IdxW'(NUM_DIGITS - 1));
    w_cnt_d    = w_tc ? '0 : r_cnt + CntW'(1);
    w_idx_d    = w_tc ? r_idx + IdxW'(1) : r_idx;
    w_sh_val_d = i_value_valid ? i_value : r_sh_val;
    w_sh_dp_d  = i_value_valid ? i_value_dp : r_sh_dp;
    // A strobe on the wrap edge bypasses the shadow straight into the new frame.
    w_fr_val_d = w_wrap ? w_sh_val_d : r_fr_val;
    w_fr_dp_d  = w_wrap ? w_sh_dp_d : r_fr_dp;
    w_frame_start_d = w_wrap;

    w_state_d  = r_state;
    w_an_d     = r_an;
    w_nibble_d = r_nibble;
    w_dp_n_d   = r_dp_n;

    if (w_tc) begin
      w_state_d  = StBlank;
      w_an_d     = '1;
      w_nibble_d = w_fr_val_d[DIGIT_W*w_idx_d +: DIGIT_W];
      w_dp_n_d   = ~w_fr_dp_d[w_idx_d];
    end else begin
      unique case (r_state)
        StBlank: begin
          if (r_cnt == BlankLast) begin
            w_state_d = StShow;
            w_an_d    = w_visible[r_idx] ? ~(NUM_DIGITS'(1) << r_idx) : '1;
          end
        end
        StShow: ;
        default: w_state_d = StBlank;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StBlank;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_sh_val      <= '0;
      r_sh_dp       <= '0;
      r_fr_val      <= '0;
      r_fr_dp       <= '0;
      r_an          <= '1;
      r_nibble      <= '0;
      r_dp_n        <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_idx         <= w_idx_d;
      r_sh_val      <= w_sh_val_d;
      r_sh_dp       <= w_sh_dp_d;
      r_fr_val      <= w_fr_val_d;
      r_fr_dp       <= w_fr_dp_d;
      r_an          <= w_an_d;
      r_nibble      <= w_nibble_d;
      r_dp_n        <= w_dp_n_d;
      r_frame_start <= w_frame_start_d;
    end
  end

  assign o_an          = r_an;
  assign o_nibble      = r_nibble;
  assign o_dp_n        = r_dp_n;
  assign o_digit_idx   = r_idx;
  assign o_frame_start = r_frame_start;

endmodule
